// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-read-port register file. It supports
//                byte-enable writes, optional write-first bypass, an optional
//                hardwired-zero entry 0, and a clear engine that zeroes every
//                entry after reset or when clear_req is pulsed.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic                       busy
);

    localparam int               c_DEPTH     = 2**ADDR_W;
    localparam int               c_NBYTE     = DATA_W/8;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_CLEAR = c_ST_CLEAR
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clrCnt;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem    [c_DEPTH];
    logic [DATA_W-1:0]   r_rdData [NUM_RD];

    logic                w_wrHit;
    logic [DATA_W-1:0]   w_mask;
    logic                w_memWe;
    logic [ADDR_W-1:0]   w_memAddr;
    logic [DATA_W-1:0]   w_memData;
    logic [c_NBYTE-1:0]  w_memBe;

    // A write that is not aimed at the hardwired-zero entry
    assign w_wrHit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // Byte enables expanded to a bit mask for the bypass merge
    for (genvar b = 0; b < c_NBYTE; b++) begin : g_mask
        assign w_mask[b*8 +: 8] = {8{wr_be[b]}};
    end

    // Single shared write port: the clear engine borrows it while clearing,
    // which keeps the array mappable onto distributed RAM
    always_comb begin
        w_memWe   = 1'b0;
        w_memAddr = wr_addr;
        w_memData = wr_data;
        w_memBe   = wr_be;
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                w_memWe   = 1'b1;
                w_memAddr = r_clrCnt;
                w_memData = '0;
                w_memBe   = '1;
            end else if (w_wrHit) begin
                w_memWe   = 1'b1;
            end
        end
    end

    // Storage array: byte-granular write, no reset so RAM inference is possible
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int b = 0; b < c_NBYTE; b++) begin
                if (w_memBe[b]) begin
                    r_mem[w_memAddr][b*8 +: 8] <= w_memData[b*8 +: 8];
                end
            end
        end
    end

    // Clear engine: walks every entry once after reset or on clear_req
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_CLEAR;
            r_clrCnt <= '0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clrCnt <= r_clrCnt + 1'b1;
                    if (r_clrCnt == c_LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (clear_req) begin
                        r_state  <= ST_CLEAR;
                        r_clrCnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;

    // Independent registered read ports
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_rdA;
        logic [DATA_W-1:0] w_rdRaw;
        logic [DATA_W-1:0] w_rdMerged;

        assign w_rdA      = rd_addr[p*ADDR_W +: ADDR_W];
        assign w_rdRaw    = r_mem[w_rdA];
        assign w_rdMerged = (w_rdRaw & ~w_mask) | (wr_data & w_mask);

        // Read register: zero while clearing, else entry (or merged write data)
        always_ff @(posedge clk) begin
            if (rst || (r_state == ST_CLEAR)) begin
                r_rdData[p] <= '0;
            end else if ((ZERO_REG != 0) && (w_rdA == '0)) begin
                r_rdData[p] <= '0;
            end else if ((BYPASS != 0) && w_wrHit && (w_rdA == wr_addr)) begin
                r_rdData[p] <= w_rdMerged;
            end else begin
                r_rdData[p] <= w_rdRaw;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = r_rdData[p];
    end

endmodule
`default_nettype wire
